spram_boot_loader_ctrl: RTL and testbench
=========================================

Name: spram_boot_loader_ctrl

Overview:
Sequences the power-up copy of NUM_IMAGES program/data images from SPI flash (through spi_fifo) into the SPRAM banks, one bank per image. Drives the spi_fifo fill/reset and flash-address controls, generates the SPRAM write port for the bank being loaded, and releases the SoC (load_done_o) only after all images are loaded and hard IP configuration has finished.

Parameters:
NUM_IMAGES, 2, number of images/banks loaded in order 0..NUM_IMAGES-1
ADDR_W, 14, SPRAM word-address width
MIN_WORDS, 1024, end marker ignored while word address < MIN_WORDS
END_MARKER, 32'hFFFF_FFFF, word value that terminates an image
GAP_CYCLES, 4, cycles fifo_rst_o is held between images (>=1)
FLASH_BASE0, 24'h030000, flash byte address of image 0
FLASH_STRIDE, 24'h020000, image k address = FLASH_BASE0 + k*FLASH_STRIDE

Ports:
clk_i  in  1  system clock (clk_soc domain)
rst_i  in  1  synchronous reset, active-high
ip_done_i  in  1  hard IP configuration complete
spi_we_i  in  1  spi_fifo word valid (one-cycle strobe per word)
spi_din_i  in  32  spi_fifo word
fill_o  out  1  spi_fifo fill request
fifo_rst_o  out  1  spi_fifo reset request, active-high
flash_addr_o  out  24  flash start address for current image
bank_sel_o  out  NUM_IMAGES  one-hot bank owned by loader; 0 = SoC owns all banks
mem_addr_o  out  ADDR_W  loader SPRAM word address
mem_din_o  out  32  loader SPRAM write data
mem_we_o  out  1  loader SPRAM write enable
mem_maskwe_o  out  4  always 4'b1111
load_done_o  out  1  SoC may leave reset
err_o  out  1  image overflowed bank without end marker (sticky)

Behaviour:
- States: FILL, GAP, WAIT_IP, DONE, ERROR. Register img_idx (clog2 NUM_IMAGES), addr (ADDR_W), gap_cnt.
- Reset (rst_i=1 at clock edge): state=FILL, img_idx=0, addr=0, gap_cnt=0, err_o=0, load_done_o=0. fill_o=0 and fifo_rst_o=1 during the reset cycle; all outputs registered or decoded from registers only (mem_we_o/mem_din_o excepted, see below).
- FILL: fill_o=1, fifo_rst_o=0, bank_sel_o=1<<img_idx, flash_addr_o=FLASH_BASE0+img_idx*FLASH_STRIDE. mem_we_o=spi_we_i, mem_din_o=spi_din_i combinationally (zero-latency write of each word at current addr); addr increments after each write.
- End marker: spi_we_i && spi_din_i==END_MARKER && addr>=MIN_WORDS -> marker word is still written; next state GAP if img_idx<NUM_IMAGES-1, else WAIT_IP. Marker at addr<MIN_WORDS is ordinary data.
- Overflow: write at addr==2^ADDR_W-1 that is not a qualifying marker -> err_o=1, state ERROR; addr does not wrap.
- GAP: fill_o=0, fifo_rst_o=1, bank_sel_o=0, mem_we_o=0, addr=0; stays exactly GAP_CYCLES cycles, then img_idx+1, FILL. spi_we_i ignored.
- WAIT_IP: fill_o=0, fifo_rst_o=1, bank_sel_o=0; ip_done_i=1 -> DONE (ip_done_i already high on entry -> DONE next cycle).
- DONE: load_done_o=1 registered, sticky until rst_i even if ip_done_i drops. fifo_rst_o=1.
- ERROR: all controls idle (fill_o=0, fifo_rst_o=1, bank_sel_o=0, mem_we_o=0), load_done_o=0, terminal until rst_i.
- spi_we_i outside FILL: ignored, mem_we_o=0.
- rst_i mid-load: restarts from image 0, addr 0, next cycle.

Decomposition:
- Package spram_loader_pkg: state enum, END_MARKER default, MASK_ALL=4'b1111, flash layout constants.
- No sub-module required; bank write-port mux (loader vs SoC per bank_sel_o) stays at top level.

Test Plan:
- Image 0 with 1500 words then END_MARKER, image 1 with 1100 words then marker, ip_done_i high -> bank 0 addrs 0..1500 written (1500 = marker), GAP 4 cycles with fifo_rst_o=1, flash_addr_o 030000 then 050000, load_done_o=1 one cycle after WAIT_IP.
- END_MARKER at addr 10 of image 0 -> written as data, stays in FILL, addr becomes 11.
- Both images end; ip_done_i held low 50 cycles then high -> load_done_o stays 0 for 50 cycles, rises the cycle after ip_done_i; ip_done_i drop later leaves it 1.
- Feed 16384 non-marker words to image 0 -> err_o=1 after word 16383, ERROR, fill_o=0, load_done_o stays 0.
- rst_i pulsed during image 1 at addr 300 -> next cycle img_idx=0, addr=0, flash_addr_o=030000, err_o=0.
- spi_we_i pulsed during GAP and WAIT_IP -> mem_we_o stays 0, addr unchanged.

Source files
------------

// File: rtl/spram_loader_pkg.sv
// Shared constants for the SPRAM boot loader: FSM encodings, flash layout
// defaults and the image start-address helper.
package spram_loader_pkg;

   // FSM state encodings
   localparam logic [2:0] StFill   = 3'd0;
   localparam logic [2:0] StGap    = 3'd1;
   localparam logic [2:0] StWaitIp = 3'd2;
   localparam logic [2:0] StDone   = 3'd3;
   localparam logic [2:0] StError  = 3'd4;

   localparam logic [31:0] END_MARKER_DEF   = 32'hFFFF_FFFF;
   localparam logic [3:0]  MASK_ALL         = 4'b1111;
   localparam logic [23:0] FLASH_BASE0_DEF  = 24'h030000;
   localparam logic [23:0] FLASH_STRIDE_DEF = 24'h020000;

   // Flash byte address of image idx; wraps modulo 2^24 like the flash bus.
   function automatic logic [23:0] image_addr(input logic [23:0] base,
                                              input logic [23:0] stride,
                                              input int unsigned idx);
      logic [31:0] tmp;
      tmp = 32'(base) + 32'(stride) * idx;
      return tmp[23:0];
   endfunction

endpackage

// File: rtl/spram_boot_loader_ctrl.sv
// Power-up loader: copies NUM_IMAGES images from SPI flash (via spi_fifo)
// into SPRAM banks, one bank per image, then releases the SoC once the hard
// IP configuration has also completed.
module spram_boot_loader_ctrl
   import spram_loader_pkg::*;
#(
   parameter int unsigned NUM_IMAGES   = 2,
   parameter int unsigned ADDR_W       = 14,
   parameter int unsigned MIN_WORDS    = 1024,
   parameter logic [31:0] END_MARKER   = END_MARKER_DEF,
   parameter int unsigned GAP_CYCLES   = 4,
   parameter logic [23:0] FLASH_BASE0  = FLASH_BASE0_DEF,
   parameter logic [23:0] FLASH_STRIDE = FLASH_STRIDE_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  ip_done_i,
   input  logic                  spi_we_i,
   input  logic [31:0]           spi_din_i,
   output logic                  fill_o,
   output logic                  fifo_rst_o,
   output logic [23:0]           flash_addr_o,
   output logic [NUM_IMAGES-1:0] bank_sel_o,
   output logic [ADDR_W-1:0]     mem_addr_o,
   output logic [31:0]           mem_din_o,
   output logic                  mem_we_o,
   output logic [3:0]            mem_maskwe_o,
   output logic                  load_done_o,
   output logic                  err_o
);

   localparam int unsigned IdxW = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1;
   localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);

   logic [2:0]        state_q, state_d;
   logic [IdxW-1:0]   img_idx_q, img_idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
   logic              err_q, err_d;
   logic              done_q, done_d;

   logic in_fill;
   logic wr;
   logic is_marker;
   logic last_img;
   logic addr_full;

   assign in_fill   = (state_q == StFill);
   // Writes are suppressed while reset is asserted so a stale FILL state
   // cannot corrupt the bank during the reset cycle.
   assign wr        = in_fill && spi_we_i && !rst_i;
   assign is_marker = (spi_din_i == END_MARKER) && (32'(addr_q) >= MIN_WORDS);
   assign last_img  = (img_idx_q == IdxW'(NUM_IMAGES - 1));
   assign addr_full = (addr_q == {ADDR_W{1'b1}});

   // Next-state logic for the load sequencer
   always_comb begin
      state_d   = state_q;
      img_idx_d = img_idx_q;
      addr_d    = addr_q;
      gap_cnt_d = gap_cnt_q;
      err_d     = err_q;
      done_d    = done_q;
      case (state_q)
         StFill: begin
            if (wr) begin
               if (is_marker) begin
                  addr_d    = '0;
                  gap_cnt_d = '0;
                  state_d   = last_img ? StWaitIp : StGap;
               end else if (addr_full) begin
                  // Bank exhausted without a terminator: stop, do not wrap.
                  err_d   = 1'b1;
                  state_d = StError;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         StGap: begin
            addr_d = '0;
            if (gap_cnt_q == GapW'(GAP_CYCLES - 1)) begin
               gap_cnt_d = '0;
               img_idx_d = img_idx_q + 1'b1;
               state_d   = StFill;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         StWaitIp: begin
            if (ip_done_i) begin
               done_d  = 1'b1;
               state_d = StDone;
            end
         end
         StDone:  done_d = 1'b1;
         StError: err_d  = 1'b1;
         default: state_d = StError;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StFill;
         img_idx_q <= '0;
         addr_q    <= '0;
         gap_cnt_q <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         img_idx_q <= img_idx_d;
         addr_q    <= addr_d;
         gap_cnt_q <= gap_cnt_d;
         err_q     <= err_d;
         done_q    <= done_d;
      end
   end

   // Output decode from registered state; write port is a pass-through
   always_comb begin
      fill_o       = in_fill && !rst_i;
      fifo_rst_o   = !(in_fill && !rst_i);
      flash_addr_o = image_addr(FLASH_BASE0, FLASH_STRIDE, 32'(img_idx_q));
      bank_sel_o   = in_fill ? (NUM_IMAGES'(1) << img_idx_q) : '0;
      mem_addr_o   = addr_q;
      mem_din_o    = spi_din_i;
      mem_we_o     = wr;
      mem_maskwe_o = MASK_ALL;
      load_done_o  = done_q;
      err_o        = err_q;
   end

endmodule

// File: tb/tb_spram_boot_loader_ctrl.sv
// Directed bench for spram_boot_loader_ctrl with hand-computed expectations.
module tb_spram_boot_loader_ctrl;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        ip_done_i;
   logic        spi_we_i;
   logic [31:0] spi_din_i;
   logic        fill_o;
   logic        fifo_rst_o;
   logic [23:0] flash_addr_o;
   logic [1:0]  bank_sel_o;
   logic [13:0] mem_addr_o;
   logic [31:0] mem_din_o;
   logic        mem_we_o;
   logic [3:0]  mem_maskwe_o;
   logic        load_done_o;
   logic        err_o;

   int total = 0;
   int bad   = 0;

   spram_boot_loader_ctrl dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .ip_done_i    (ip_done_i),
      .spi_we_i     (spi_we_i),
      .spi_din_i    (spi_din_i),
      .fill_o       (fill_o),
      .fifo_rst_o   (fifo_rst_o),
      .flash_addr_o (flash_addr_o),
      .bank_sel_o   (bank_sel_o),
      .mem_addr_o   (mem_addr_o),
      .mem_din_o    (mem_din_o),
      .mem_we_o     (mem_we_o),
      .mem_maskwe_o (mem_maskwe_o),
      .load_done_o  (load_done_o),
      .err_o        (err_o)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Feed n consecutive non-marker words, one per cycle.
   task automatic feed(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         spi_we_i  = 1'b1;
         spi_din_i = base + 32'(i);
         tick();
      end
      spi_we_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
      #1;
   endtask

   initial begin
      int gap;
      int hi;
      rst_i     = 1'b1;
      ip_done_i = 1'b0;
      spi_we_i  = 1'b0;
      spi_din_i = '0;
      tick();
      tick();
      // Reset cycle
      check("rst_fill", 32'(fill_o), 0);
      check("rst_fifo_rst", 32'(fifo_rst_o), 1);
      rst_i = 1'b0;
      #1;
      check("init_fill", 32'(fill_o), 1);
      check("init_fifo_rst", 32'(fifo_rst_o), 0);
      check("init_bank", 32'(bank_sel_o), 32'h1);
      check("init_flash", 32'(flash_addr_o), 32'h030000);
      check("init_addr", 32'(mem_addr_o), 0);
      check("init_err", 32'(err_o), 0);
      check("init_done", 32'(load_done_o), 0);
      check("maskwe", 32'(mem_maskwe_o), 32'hF);

      // Marker below MIN_WORDS is ordinary data
      feed(10, 32'h1000);
      spi_we_i  = 1'b1;
      spi_din_i = 32'hFFFF_FFFF;
      #1;
      check("early_mk_we", 32'(mem_we_o), 1);
      check("early_mk_din", mem_din_o, 32'hFFFF_FFFF);
      check("early_mk_addr", 32'(mem_addr_o), 10);
      tick();
      spi_we_i = 1'b0;
      check("early_mk_next_addr", 32'(mem_addr_o), 11);
      check("early_mk_fill", 32'(fill_o), 1);
      // Idle cycle must not advance the address
      tick();
      check("idle_addr", 32'(mem_addr_o), 11);

      // Image 0: fill to addr 1499, marker lands at 1500
      feed(1489, 32'h2000);
      spi_we_i  = 1'b1;
      spi_din_i = 32'hFFFF_FFFF;
      #1;
      check("img0_mk_addr", 32'(mem_addr_o), 1500);
      check("img0_mk_we", 32'(mem_we_o), 1);
      tick();
      // First GAP cycle, with a stray strobe
      spi_din_i = 32'h1234_5678;
      #1;
      check("gap_we", 32'(mem_we_o), 0);
      check("gap_fifo_rst", 32'(fifo_rst_o), 1);
      check("gap_bank", 32'(bank_sel_o), 0);
      check("gap_addr", 32'(mem_addr_o), 0);
      gap = 0;
      while (fill_o == 1'b0 && gap < 20) begin
         gap++;
         tick();
         spi_we_i = 1'b0;
      end
      check("gap_len", 32'(gap), 4);
      check("img1_flash", 32'(flash_addr_o), 32'h050000);
      check("img1_bank", 32'(bank_sel_o), 32'h2);
      check("img1_addr", 32'(mem_addr_o), 0);

      // Image 1: 1100 words then marker
      feed(1100, 32'h3000);
      check("img1_pre_mk_addr", 32'(mem_addr_o), 1100);
      spi_we_i  = 1'b1;
      spi_din_i = 32'hFFFF_FFFF;
      tick();
      // Now in WAIT_IP with ip_done low; stray strobe is ignored
      spi_din_i = 32'h5555_0000;
      #1;
      check("wait_we", 32'(mem_we_o), 0);
      check("wait_fill", 32'(fill_o), 0);
      check("wait_fifo_rst", 32'(fifo_rst_o), 1);
      tick();
      spi_we_i = 1'b0;
      check("wait_addr", 32'(mem_addr_o), 0);
      hi = 0;
      for (int i = 0; i < 50; i++) begin
         if (load_done_o) hi++;
         tick();
      end
      check("wait50_done_hi", 32'(hi), 0);
      ip_done_i = 1'b1;
      #1;
      check("ip_edge_done", 32'(load_done_o), 0);
      tick();
      check("ip_next_done", 32'(load_done_o), 1);
      ip_done_i = 1'b0;
      tick();
      tick();
      check("done_sticky", 32'(load_done_o), 1);
      check("done_fifo_rst", 32'(fifo_rst_o), 1);
      check("done_fill", 32'(fill_o), 0);

      // Reset mid image 1, at addr 300
      do_reset();
      feed(1023, 32'h4000);
      spi_we_i  = 1'b1;
      spi_din_i = 32'hFFFF_FFFF;  // addr 1023 < MIN_WORDS: data
      tick();
      spi_we_i = 1'b0;
      check("mk1023_fill", 32'(fill_o), 1);
      check("mk1023_addr", 32'(mem_addr_o), 1024);
      spi_we_i = 1'b1;            // addr 1024: qualifying marker
      tick();
      spi_we_i = 1'b0;
      check("mk1024_fill", 32'(fill_o), 0);
      for (int i = 0; i < 4; i++) tick();
      check("r_img1_flash", 32'(flash_addr_o), 32'h050000);
      feed(300, 32'h6000);
      check("r_img1_addr", 32'(mem_addr_o), 300);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      #1;
      check("r_addr", 32'(mem_addr_o), 0);
      check("r_flash", 32'(flash_addr_o), 32'h030000);
      check("r_bank", 32'(bank_sel_o), 32'h1);
      check("r_err", 32'(err_o), 0);

      // Full load with ip_done already high
      ip_done_i = 1'b1;
      feed(1024, 32'h7000);
      spi_we_i  = 1'b1;
      spi_din_i = 32'hFFFF_FFFF;
      tick();
      spi_we_i = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      feed(1024, 32'h8000);
      spi_we_i  = 1'b1;
      spi_din_i = 32'hFFFF_FFFF;
      tick();
      spi_we_i = 1'b0;
      check("ipe_wait_done", 32'(load_done_o), 0);
      tick();
      check("ipe_done", 32'(load_done_o), 1);
      ip_done_i = 1'b0;

      // Overflow of image 0
      do_reset();
      feed(16383, 32'h0001_0000);
      check("ovf_last_addr", 32'(mem_addr_o), 16383);
      check("ovf_pre_err", 32'(err_o), 0);
      spi_we_i  = 1'b1;
      spi_din_i = 32'hABCD_0000;
      #1;
      check("ovf_last_we", 32'(mem_we_o), 1);
      check("ovf_last_din", mem_din_o, 32'hABCD_0000);
      tick();
      check("ovf_err", 32'(err_o), 1);
      check("ovf_fill", 32'(fill_o), 0);
      check("ovf_fifo_rst", 32'(fifo_rst_o), 1);
      check("ovf_we", 32'(mem_we_o), 0);
      check("ovf_bank", 32'(bank_sel_o), 0);
      check("ovf_nowrap", 32'(mem_addr_o), 16383);
      spi_we_i  = 1'b0;
      ip_done_i = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check("ovf_done", 32'(load_done_o), 0);
      check("ovf_err_sticky", 32'(err_o), 1);
      ip_done_i = 1'b0;
      do_reset();
      check("ovf_rst_err", 32'(err_o), 0);
      check("ovf_rst_fill", 32'(fill_o), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "timeout");
   end

endmodule
